adder_result_checker: RTL and testbench
=======================================

Name: adder_result_checker

Overview:
- Self-checking monitor on the consumer side of the registered adder: captures the operand stream and recomputes the expected sum.
- Aligns the expected sum with the adder's registered output and compares them.
- Reports per-check mismatches, saturating counters and a sticky fail flag.
- Sits beside the adder wrapper in simulation benches and is synthesizable for on-chip self-test.

Parameters:
- WIDTH, 4, operand width; the sum is WIDTH+1 bits.
- LATENCY, 1, cycles from operands to the adder's registered sum; must be >= 1.
- ERR_CNT_W, 8, error counter width.
- CHK_CNT_W, 16, check counter width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- en  input  1  in1/in2 are valid this cycle.
- in1  input  WIDTH  operand A, as driven to the adder.
- in2  input  WIDTH  operand B, as driven to the adder.
- sum  input  WIDTH+1  adder output.
- mismatch  output  1  one-cycle pulse per failed comparison.
- fail  output  1  sticky: at least one mismatch since reset.
- err_cnt  output  ERR_CNT_W  saturating mismatch count.
- chk_cnt  output  CHK_CNT_W  saturating count of comparisons performed.
- state  output  2  FSM state encoding.
- first_exp  output  WIDTH+1  expected value of the first mismatch (optional feature).
- first_act  output  WIDTH+1  actual value of the first mismatch (optional feature).

Behaviour:
- Reset (async assert, sync release): all outputs 0, state=IDLE (2'd0), delay line fully cleared (all valid bits 0).
- Expected sum = zero-extended in1 + in2, computed at WIDTH+1 bits; no truncation.
- Delay line: LATENCY stages of {valid, expected}.
  - Stage 0 loads {en, in1+in2} every cycle.
  - The output of stage LATENCY-1 is the comparison point: it lines up with `sum` in the same cycle.
- Comparison happens when the delayed valid is 1.
  - Mismatch when sum != delayed expected.
  - mismatch is registered: it pulses in the cycle after the comparison cycle.
  - Total en-to-mismatch latency is LATENCY+1.
- chk_cnt: +1 per comparison; holds at all-ones (no wrap).
- err_cnt: +1 per mismatch; holds at all-ones.
- fail: set on the first mismatch, cleared only by rst.
- FSM:
  - IDLE(0): no operands seen yet. en=1 -> WARMUP.
  - WARMUP(1): pipeline filling; counts LATENCY-1 cycles. If LATENCY==1, goes directly to CHECKING on the next cycle.
  - CHECKING(2): comparisons active. First mismatch -> FAILED.
  - FAILED(3): terminal until rst. Comparisons and counting continue.
  - en deasserted in any state does not move the FSM backward; bubbles simply produce no comparison.
- Back-to-back en: one comparison per cycle, no stalls.
- en=0 gaps: no comparison, counters hold, no mismatch pulse.
- Simultaneous first mismatch and counter saturation: fail and the state change still occur.
- rst mid-stream: in-flight expected values are discarded; no comparison occurs in the cycle after release.
- `sum` is sampled only in comparison cycles; its value otherwise is don't-care.

Optional Feature:
- Macro: ADDER_CHECKER_CAPTURE_EN.
- Defined: on the first mismatch only, first_exp/first_act latch the expected value and `sum` from the comparison cycle.
  - They become valid in the same cycle fail rises.
  - They hold until rst.
- Undefined: first_exp and first_act are tied to 0 and no capture registers are instantiated.

Test Plan:
- Reset: assert rst mid-cycle with clk toggling -> immediately mismatch=0, fail=0, err_cnt=0, chk_cnt=0, state=0.
- Correct adder, in1=4'b0101, in2=4'b0011, en held 20 cycles, LATENCY=1 -> chk_cnt=20, err_cnt=0, state=2, no mismatch pulse.
- Overflow: in1=4'hF, in2=4'h1, sum=5'b10000 -> pass. Force sum=5'b00000 -> mismatch pulses 2 cycles after en, fail=1, state=3, err_cnt=1. With capture macro: first_exp=5'h10, first_act=5'h00.
- Gapped stream: en pattern 1,0,1,1,0 with a correct sum -> chk_cnt=3, no mismatch; state IDLE->WARMUP->CHECKING.
- Saturation, ERR_CNT_W=2: inject 6 consecutive wrong sums -> err_cnt=3 and holds, fail=1, chk_cnt=6.
- rst pulse with 1 in-flight op at LATENCY=3 -> after release chk_cnt stays 0 for 3 cycles even though sum is wrong; state=0.

Source files
------------

// File: rtl/adder_result_checker_if.sv
// Operand/result bus between an adder stimulus source and adder_result_checker.
// The master drives the operands and the adder result; the checker (slave) drives the status signals.
interface adder_result_checker_if #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8,
    parameter int CHK_CNT_W = 16
);
    logic                 en;
    logic [WIDTH-1:0]     in1;
    logic [WIDTH-1:0]     in2;
    logic [WIDTH:0]       sum;
    logic                 mismatch;
    logic                 fail;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic [CHK_CNT_W-1:0] chk_cnt;
    logic [1:0]           state;
    logic [WIDTH:0]       first_exp;
    logic [WIDTH:0]       first_act;

    modport master (
        output en, in1, in2, sum,
        input  mismatch, fail, err_cnt, chk_cnt, state, first_exp, first_act
    );

    modport slave (
        input  en, in1, in2, sum,
        output mismatch, fail, err_cnt, chk_cnt, state, first_exp, first_act
    );
endinterface

// File: rtl/adder_result_checker.sv
// Consumer-side checker for the registered adder: delays in1+in2 by LATENCY and compares against sum.
// Optional first-mismatch capture of expected/actual values is enabled by `define ADDER_CHECKER_CAPTURE_EN.
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   IDLE     | no operands seen since reset
//   WARMUP   | pipeline filling, LATENCY-1 cycles (1 if LATENCY==1)
//   CHECKING | comparisons active, no mismatch yet
//   FAILED   | at least one mismatch; terminal until rst
//
// The bus interface instance must use the same WIDTH/ERR_CNT_W/CHK_CNT_W as this module.
module adder_result_checker #(
    parameter int WIDTH     = 4,
    parameter int LATENCY   = 1,
    parameter int ERR_CNT_W = 8,
    parameter int CHK_CNT_W = 16
) (
    input logic                 clk,
    input logic                 rst,
    adder_result_checker_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WARMUP   = 2'd1,
        CHECKING = 2'd2,
        FAILED   = 2'd3
    } state_t;

    localparam int WC_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [WC_W-1:0] WARM_LOAD = WC_W'((LATENCY > 1) ? LATENCY - 2 : 0);

    logic [LATENCY-1:0]   vld_q;
    logic [WIDTH:0]       exp_q [LATENCY];
    logic [WIDTH:0]       exp_d;
    logic                 cmp_vld;
    logic                 cmp_bad;

    state_t               state_q;
    logic [WC_W-1:0]      wcnt_q;
    logic                 mismatch_q;
    logic                 fail_q;
    logic [ERR_CNT_W-1:0] err_q;
    logic [CHK_CNT_W-1:0] chk_q;

    assign exp_d = {1'b0, bus.in1} + {1'b0, bus.in2};

    // Stage LATENCY-1 is the comparison point, aligned with the adder's registered sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                exp_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= bus.en;
            exp_q[0] <= exp_d;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                exp_q[i] <= exp_q[i-1];
            end
        end
    end

    assign cmp_vld = vld_q[LATENCY-1];
    assign cmp_bad = cmp_vld && (bus.sum != exp_q[LATENCY-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wcnt_q     <= '0;
            mismatch_q <= 1'b0;
            fail_q     <= 1'b0;
            err_q      <= '0;
            chk_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.en) begin
                        state_q <= WARMUP;
                        wcnt_q  <= WARM_LOAD;
                    end
                end
                WARMUP: begin
                    if (wcnt_q == '0) begin
                        state_q <= CHECKING;
                    end else begin
                        wcnt_q <= wcnt_q - 1'b1;
                    end
                end
                default: ;
            endcase

            // Comparisons run off the delayed valid alone, so checks during WARMUP still count.
            if (cmp_bad) begin
                state_q <= FAILED;
                fail_q  <= 1'b1;
            end

            mismatch_q <= cmp_bad;

            if (cmp_vld && !(&chk_q)) begin
                chk_q <= chk_q + 1'b1;
            end
            if (cmp_bad && !(&err_q)) begin
                err_q <= err_q + 1'b1;
            end
        end
    end

    assign bus.mismatch = mismatch_q;
    assign bus.fail     = fail_q;
    assign bus.err_cnt  = err_q;
    assign bus.chk_cnt  = chk_q;
    assign bus.state    = state_q;

`ifdef ADDER_CHECKER_CAPTURE_EN
    logic [WIDTH:0] first_exp_q;
    logic [WIDTH:0] first_act_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_exp_q <= '0;
            first_act_q <= '0;
        end else if (cmp_bad && !fail_q) begin
            first_exp_q <= exp_q[LATENCY-1];
            first_act_q <= bus.sum;
        end
    end

    assign bus.first_exp = first_exp_q;
    assign bus.first_act = first_act_q;
`else
    assign bus.first_exp = '0;
    assign bus.first_act = '0;
`endif

endmodule

// File: tb/tb_adder_result_checker.sv
// Self-checking bench for adder_result_checker: one LATENCY=1/ERR_CNT_W=2 instance and one LATENCY=3 instance
// share the operand stream; a cycle-indexed history model supplies the expected results.
module tb_adder_result_checker;

    localparam int W     = 4;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int EW_A  = 2;
    localparam int EW_B  = 8;
    localparam int CW    = 16;
    localparam int HMAX  = 4096;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         en    = 1'b0;
    logic [W-1:0] in1   = '0;
    logic [W-1:0] in2   = '0;
    logic [W:0]   sum_a = '0;
    logic [W:0]   sum_b = '0;

    adder_result_checker_if #(.WIDTH(W), .ERR_CNT_W(EW_A), .CHK_CNT_W(CW)) ifa ();
    adder_result_checker_if #(.WIDTH(W), .ERR_CNT_W(EW_B), .CHK_CNT_W(CW)) ifb ();

    assign ifa.en  = en;
    assign ifa.in1 = in1;
    assign ifa.in2 = in2;
    assign ifa.sum = sum_a;
    assign ifb.en  = en;
    assign ifb.in1 = in1;
    assign ifb.in2 = in2;
    assign ifb.sum = sum_b;

    adder_result_checker #(.WIDTH(W), .LATENCY(LAT_A), .ERR_CNT_W(EW_A), .CHK_CNT_W(CW)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    adder_result_checker #(.WIDTH(W), .LATENCY(LAT_B), .ERR_CNT_W(EW_B), .CHK_CNT_W(CW)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // History of what was offered in each cycle; expected results are looked up by cycle number.
    bit         hv [HMAX];
    logic [W:0] he [HMAX];

    int         m_chk   [2];
    int         m_err   [2];
    bit         m_fail  [2];
    bit         m_mis   [2];
    bit         m_seen  [2];
    int         m_first [2];
    int         m_from  [2];
    int         m_state [2];
    logic [W:0] m_fexp  [2];
    logic [W:0] m_fact  [2];

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT_A : LAT_B;
    endfunction

    function automatic int err_max(input int i);
        return (i == 0) ? (1 << EW_A) - 1 : (1 << EW_B) - 1;
    endfunction

    function automatic int warm_len(input int i);
        return (lat_of(i) > 1) ? lat_of(i) - 1 : 1;
    endfunction

    // Correct adder output for the current cycle on instance i.
    function automatic logic [W:0] corr(input int i);
        int j;
        j = cyc - lat_of(i);
        if (j >= 0) return he[j];
        return '0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_chk[i]   = 0;
            m_err[i]   = 0;
            m_fail[i]  = 1'b0;
            m_mis[i]   = 1'b0;
            m_seen[i]  = 1'b0;
            m_first[i] = 0;
            m_from[i]  = cyc;
            m_state[i] = 0;
            m_fexp[i]  = '0;
            m_fact[i]  = '0;
        end
    endtask

    // Drive one cycle, advance the model, and return at posedge+1.
    task automatic step(input bit e, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W:0] sa, input logic [W:0] sb);
        en    = e;
        in1   = a;
        in2   = b;
        sum_a = sa;
        sum_b = sb;
        hv[cyc] = e;
        he[cyc] = {1'b0, a} + {1'b0, b};
        for (int i = 0; i < 2; i++) begin
            int j;
            bit cmp;
            bit bad;
            logic [W:0] s;
            j   = cyc - lat_of(i);
            s   = (i == 0) ? sa : sb;
            cmp = 1'b0;
            bad = 1'b0;
            if (j >= 0 && j >= m_from[i]) begin
                cmp = hv[j];
                bad = hv[j] && (s != he[j]);
            end
            if (cmp && m_chk[i] < 65535) m_chk[i]++;
            if (bad && m_err[i] < err_max(i)) m_err[i]++;
            if (bad && !m_fail[i]) begin
                m_fexp[i] = he[j];
                m_fact[i] = s;
            end
            if (bad) m_fail[i] = 1'b1;
            m_mis[i] = bad;
            if (e && !m_seen[i]) begin
                m_seen[i]  = 1'b1;
                m_first[i] = cyc;
            end
            if (m_fail[i])                         m_state[i] = 3;
            else if (!m_seen[i])                   m_state[i] = 0;
            else if (cyc < m_first[i] + warm_len(i)) m_state[i] = 1;
            else                                   m_state[i] = 2;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        en = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++; if (ifa.mismatch !== 1'b0) begin errors++; $display("FAIL reset_mismatch: got %0b want 0", ifa.mismatch); end
        checks++; if (ifa.fail !== 1'b0)     begin errors++; $display("FAIL reset_fail: got %0b want 0", ifa.fail); end
        checks++; if (ifa.err_cnt !== '0)    begin errors++; $display("FAIL reset_err: got %0d want 0", ifa.err_cnt); end
        checks++; if (ifa.chk_cnt !== '0)    begin errors++; $display("FAIL reset_chk: got %0d want 0", ifa.chk_cnt); end
        checks++; if (ifa.state !== 2'd0)    begin errors++; $display("FAIL reset_state_a: got %0d want 0", ifa.state); end
        checks++; if (ifb.state !== 2'd0)    begin errors++; $display("FAIL reset_state_b: got %0d want 0", ifb.state); end
        checks++; if (ifa.first_exp !== '0 || ifa.first_act !== '0) begin
            errors++; $display("FAIL reset_capture: got %0h/%0h want 0/0", ifa.first_exp, ifa.first_act);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_steady();
        for (int k = 0; k < 23; k++) begin
            step(k < 20, 4'b0101, 4'b0011, corr(0), corr(1));
            checks++; if (ifa.mismatch !== 1'b0) begin errors++; $display("FAIL steady_pulse: cycle %0d got %0b want 0", k, ifa.mismatch); end
        end
        checks++; if (ifa.chk_cnt !== 16'd20) begin errors++; $display("FAIL steady_chk_a: got %0d want 20", ifa.chk_cnt); end
        checks++; if (ifa.err_cnt !== '0)     begin errors++; $display("FAIL steady_err_a: got %0d want 0", ifa.err_cnt); end
        checks++; if (ifa.state !== 2'd2)     begin errors++; $display("FAIL steady_state_a: got %0d want 2", ifa.state); end
        checks++; if (ifb.chk_cnt !== 16'd20) begin errors++; $display("FAIL steady_chk_b: got %0d want 20", ifb.chk_cnt); end
        checks++; if (ifb.state !== 2'd2)     begin errors++; $display("FAIL steady_state_b: got %0d want 2", ifb.state); end
    endtask

    task automatic test_overflow();
        do_reset();
        step(1'b1, 4'hF, 4'h1, corr(0), corr(1));
        step(1'b0, 4'h0, 4'h0, 5'b10000, corr(1));
        checks++; if (ifa.chk_cnt !== 16'd1 || ifa.mismatch !== 1'b0) begin
            errors++; $display("FAIL ovf_pass: got chk=%0d mis=%0b want chk=1 mis=0", ifa.chk_cnt, ifa.mismatch);
        end
        step(1'b1, 4'hF, 4'h1, 5'($urandom), corr(1));
        step(1'b0, 4'h0, 4'h0, 5'b00000, corr(1));
        checks++; if (ifa.mismatch !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %0b want 1", ifa.mismatch); end
        checks++; if (ifa.fail !== 1'b1)     begin errors++; $display("FAIL ovf_fail: got %0b want 1", ifa.fail); end
        checks++; if (ifa.state !== 2'd3)    begin errors++; $display("FAIL ovf_state: got %0d want 3", ifa.state); end
        checks++; if (ifa.err_cnt !== 2'd1)  begin errors++; $display("FAIL ovf_err: got %0d want 1", ifa.err_cnt); end
`ifdef ADDER_CHECKER_CAPTURE_EN
        checks++; if (ifa.first_exp !== 5'h10 || ifa.first_act !== 5'h00) begin
            errors++; $display("FAIL ovf_capture: got %0h/%0h want 10/00", ifa.first_exp, ifa.first_act);
        end
`else
        checks++; if (ifa.first_exp !== '0 || ifa.first_act !== '0) begin
            errors++; $display("FAIL ovf_capture_off: got %0h/%0h want 0/0", ifa.first_exp, ifa.first_act);
        end
`endif
        step(1'b0, 4'h0, 4'h0, 5'($urandom), corr(1));
        checks++; if (ifa.mismatch !== 1'b0 || ifa.fail !== 1'b1) begin
            errors++; $display("FAIL ovf_after: got mis=%0b fail=%0b want mis=0 fail=1", ifa.mismatch, ifa.fail);
        end
        checks++; if (ifb.fail !== 1'b0) begin errors++; $display("FAIL ovf_b_clean: got %0b want 0", ifb.fail); end
    endtask

    task automatic test_gapped();
        bit pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        checks++; if (ifa.state !== 2'd0) begin errors++; $display("FAIL gap_idle: got %0d want 0", ifa.state); end
        for (int k = 0; k < 6; k++) begin
            step(pat[k], 4'($urandom), 4'($urandom), corr(0), corr(1));
            checks++; if (ifa.state !== 2'(m_state[0]) || ifa.mismatch !== 1'b0) begin
                errors++; $display("FAIL gap_state: cycle %0d got st=%0d mis=%0b want st=%0d mis=0", k, ifa.state, ifa.mismatch, m_state[0]);
            end
        end
        checks++; if (ifa.chk_cnt !== 16'd3) begin errors++; $display("FAIL gap_chk: got %0d want 3", ifa.chk_cnt); end
        checks++; if (ifa.state !== 2'd2)    begin errors++; $display("FAIL gap_final: got %0d want 2", ifa.state); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 7; k++) begin
            step(k < 6, 4'($urandom), 4'($urandom), corr(0) + 5'd1, corr(1));
            checks++; if (ifa.err_cnt !== 2'(m_err[0])) begin
                errors++; $display("FAIL sat_err_step: cycle %0d got %0d want %0d", k, ifa.err_cnt, m_err[0]);
            end
        end
        checks++; if (ifa.err_cnt !== 2'd3)   begin errors++; $display("FAIL sat_err: got %0d want 3", ifa.err_cnt); end
        checks++; if (ifa.fail !== 1'b1)      begin errors++; $display("FAIL sat_fail: got %0b want 1", ifa.fail); end
        checks++; if (ifa.chk_cnt !== 16'd6)  begin errors++; $display("FAIL sat_chk: got %0d want 6", ifa.chk_cnt); end
        step(1'b0, 4'h0, 4'h0, corr(0) + 5'd1, corr(1));
        checks++; if (ifa.err_cnt !== 2'd3 || ifa.mismatch !== 1'b0) begin
            errors++; $display("FAIL sat_hold: got err=%0d mis=%0b want err=3 mis=0", ifa.err_cnt, ifa.mismatch);
        end
    endtask

    task automatic test_rst_inflight();
        logic [W:0] stale;
        do_reset();
        step(1'b1, 4'($urandom), 4'($urandom), corr(0), corr(1));
        stale = he[cyc-1];
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 4'h0, 4'h0, stale + 5'd1, stale + 5'd1);
            checks++; if (ifb.chk_cnt !== '0 || ifb.mismatch !== 1'b0 || ifb.state !== 2'd0) begin
                errors++; $display("FAIL inflight: cycle %0d got chk=%0d mis=%0b st=%0d want 0/0/0", k, ifb.chk_cnt, ifb.mismatch, ifb.state);
            end
        end
        checks++; if (ifb.err_cnt !== '0) begin errors++; $display("FAIL inflight_err: got %0d want 0", ifb.err_cnt); end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            bit         e;
            logic [W:0] sa;
            logic [W:0] sb;
            e  = ($urandom_range(0, 9) < 7);
            sa = ($urandom_range(0, 19) == 0) ? 5'($urandom) : corr(0);
            sb = ($urandom_range(0, 29) == 0) ? 5'($urandom) : corr(1);
            step(e, 4'($urandom), 4'($urandom), sa, sb);
            checks++; if (ifa.mismatch !== m_mis[0] || ifa.fail !== m_fail[0] || ifa.state !== 2'(m_state[0])) begin
                errors++; $display("FAIL rand_flags_a: cycle %0d got mis=%0b fail=%0b st=%0d want %0b/%0b/%0d",
                                   k, ifa.mismatch, ifa.fail, ifa.state, m_mis[0], m_fail[0], m_state[0]);
            end
            checks++; if (ifa.chk_cnt !== 16'(m_chk[0]) || ifa.err_cnt !== 2'(m_err[0])) begin
                errors++; $display("FAIL rand_cnt_a: cycle %0d got chk=%0d err=%0d want %0d/%0d", k, ifa.chk_cnt, ifa.err_cnt, m_chk[0], m_err[0]);
            end
            checks++; if (ifb.mismatch !== m_mis[1] || ifb.fail !== m_fail[1] || ifb.state !== 2'(m_state[1])) begin
                errors++; $display("FAIL rand_flags_b: cycle %0d got mis=%0b fail=%0b st=%0d want %0b/%0b/%0d",
                                   k, ifb.mismatch, ifb.fail, ifb.state, m_mis[1], m_fail[1], m_state[1]);
            end
            checks++; if (ifb.chk_cnt !== 16'(m_chk[1]) || ifb.err_cnt !== 8'(m_err[1])) begin
                errors++; $display("FAIL rand_cnt_b: cycle %0d got chk=%0d err=%0d want %0d/%0d", k, ifb.chk_cnt, ifb.err_cnt, m_chk[1], m_err[1]);
            end
        end
`ifdef ADDER_CHECKER_CAPTURE_EN
        checks++; if (ifb.first_exp !== m_fexp[1] || ifb.first_act !== m_fact[1]) begin
            errors++; $display("FAIL rand_capture_b: got %0h/%0h want %0h/%0h", ifb.first_exp, ifb.first_act, m_fexp[1], m_fact[1]);
        end
`else
        checks++; if (ifb.first_exp !== '0 || ifb.first_act !== '0) begin
            errors++; $display("FAIL rand_capture_off: got %0h/%0h want 0/0", ifb.first_exp, ifb.first_act);
        end
`endif
    endtask

    initial begin
        model_reset();
        test_reset();
        test_steady();
        test_overflow();
        test_gapped();
        test_saturation();
        test_rst_inflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
